alu_stream: RTL and testbench

ALU_STREAM -- requirements
Module: alu_stream

---
 rtl/alu_stream_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/alu_stream.sv | 115 +++++++++++
 tb/tb_alu_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stream_pkg.sv
// Shared types, default sizing and the ALU reference function for the alu_stream block.
// The ALU function is used by both the datapath and any software-side model.
package alu_stream_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int ALU_MAX_W  = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_e;

    // Operands arrive zero-extended to ALU_MAX_W; w is the real operand width.
    // Bit w of the result carries the ADD carry or SUB borrow; higher bits stay zero.
    function automatic logic [ALU_MAX_W:0] alu_calc(
        input op_e                  op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [ALU_MAX_W:0] ea;
        logic [ALU_MAX_W:0] eb;
        logic [ALU_MAX_W:0] one;
        logic [ALU_MAX_W:0] mask;
        logic [ALU_MAX_W:0] r;
        ea   = {1'b0, a};
        eb   = {1'b0, b};
        one  = {{ALU_MAX_W{1'b0}}, 1'b1};
        mask = (one << (w + 1)) - one;
        unique case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = (ea - eb) & mask;
            OP_AND:  r = ea & eb;
            OP_XOR:  r = ea ^ eb;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read data, occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU: requests queue in a FIFO, the head is computed and held in an
// output register until the consumer takes it.
module alu_stream
    import alu_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_result,
    output logic [15:0]       done_count
);

    localparam int ENTRY_W = 2 + 2 * DATA_W;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; a producer holds its payload stable while valid is high and ready is low.

    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] unused_fifo_count;
    logic                  push;
    logic                  pop;

    logic [1:0]            head_op;
    logic [DATA_W-1:0]     head_a;
    logic [DATA_W-1:0]     head_b;
    logic [ALU_MAX_W:0]    alu_full;
    logic [DATA_W:0]       alu_res;
    logic                  unused_alu_hi;

    out_state_e            state;
    out_state_e            state_nxt;
    logic [DATA_W:0]       result_q;
    logic [15:0]           count_q;

    assign fifo_din = {in_op, in_a, in_b};
    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && (state == ST_EMPTY || out_ready) && !flush;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign {head_op, head_a, head_b} = fifo_dout;
    assign alu_full      = alu_calc(op_e'(head_op), ALU_MAX_W'(head_a), ALU_MAX_W'(head_b), DATA_W);
    assign alu_res       = alu_full[DATA_W:0];
    assign unused_alu_hi = ^alu_full[ALU_MAX_W:DATA_W+1];

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (pop) begin
            state_nxt = ST_HOLD;
        end else if (state == ST_HOLD && out_ready) begin
            state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // The result register keeps its last value while EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (pop) begin
            result_q <= alu_res;
        end
    end

    // A handshake completing in a flush cycle is still a delivered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign out_valid  = (state == ST_HOLD);
    assign out_result = result_q;
    assign done_count = count_q;

endmodule

// File: tb/tb_alu_stream.sv
// Directed bench for alu_stream: latency, opcodes, backpressure, flush, reset and streaming.
module tb_alu_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_result;
    logic [15:0] done_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [8:0]  exp_q[$];
    int          hs_cycles[$];

    alu_stream #(.DATA_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .done_count (done_count)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // scoreboard: every output handshake must match the head of exp_q
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_cycles.push_back(cyc);
            if (exp_q.size() == 0) check("out_unexpected", 32'(exp_q.size()), 32'd1);
            else check("sb_result", 32'(out_result), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp, input bit keep);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_accept", 32'(ok), 32'd1);
        else if (keep) exp_q.push_back(exp);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) step(1);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int accepted;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;

        // reset state
        step(1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        step(1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // latency: ADD 0xFF + 0x01
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd0; in_a = 8'hFF; in_b = 8'h01;
        exp_q.push_back(9'h100);
        check("lat_in_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        step(1);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_result", 32'(out_result), 32'h100);
        step(1);
        check("lat_done_count", 32'(done_count), 32'd1);

        // opcodes
        send(2'd1, 8'h03, 8'h05, 9'h1FE, 1'b1);
        send(2'd3, 8'hF0, 8'h3C, 9'h0CC, 1'b1);
        send(2'd2, 8'hF0, 8'h3C, 9'h030, 1'b1);
        in_valid = 1'b0;
        drain();
        check("ops_done_count", 32'(done_count), 32'd4);

        // backpressure: 4 FIFO entries plus the output register
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op = 2'd0; in_a = 8'(i + 1); in_b = 8'h10;
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                exp_q.push_back(9'(i + 17));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(3);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_result", 32'(out_result), 32'h011);
        out_ready = 1'b1;
        drain();
        check("bp_done_count", 32'(done_count), 32'd9);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);

        // flush with full FIFO and a held result
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(2'd0, 8'(i), 8'h01, 9'h0, 1'b0);
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", 32'(in_ready), 32'd0);
        step(1);
        flush = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_done_count", 32'(done_count), 32'd9);
        out_ready = 1'b1;
        step(6);
        check("flush_no_output", 32'(out_valid), 32'd0);
        send(2'd3, 8'hAA, 8'h55, 9'h0FF, 1'b1);
        in_valid = 1'b0;
        drain();
        check("flush_after_done", 32'(done_count), 32'd10);

        // reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd1, 8'h20, 8'(i), 9'h0, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_result", 32'(out_result), 32'd0);
        check("mid_rst_done_count", 32'(done_count), 32'd0);
        step(2);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd0; in_a = 8'h01; in_b = 8'h01;
        exp_q.push_back(9'h002);
        check("rst_lat_in_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        check("rst_lat_cycle1", 32'(out_valid), 32'd0);
        step(1);
        check("rst_lat_cycle2", 32'(out_valid), 32'd1);
        check("rst_lat_result", 32'(out_result), 32'h002);
        step(1);
        check("rst_lat_done", 32'(done_count), 32'd1);

        // streaming 100 items
        hs_cycles.delete();
        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            send(op, a, b, model(op, a, b), 1'b1);
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", 32'(hs_cycles.size()), 32'd100);
        if (hs_cycles.size() == 100)
            check("stream_span", 32'(hs_cycles[99] - hs_cycles[0]), 32'd99);
        check("stream_done_count", 32'(done_count), 32'd101);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
